// File: rtl/sram_bus_responder_if.sv
// CPU-side data bus between the MMU physical port and the SRAM responder.
// The master drives the request; the slave answers with read data and a stall.
interface sram_bus_responder_if;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_stall;

    modport master (
        output bus_address, bus_read, bus_write, bus_byte_enable, bus_data_i,
        input  bus_data_o, bus_stall
    );

    modport slave (
        input  bus_address, bus_read, bus_write, bus_byte_enable, bus_data_i,
        output bus_data_o, bus_stall
    );
endinterface

// File: rtl/sram_bus_responder.sv
// Bus slave that turns level-held CPU read/write requests into timed cycles
// on an external asynchronous 32-bit SRAM, stalling the pipeline until done.
// Every SRAM-side output comes straight from a flop so the board sees clean
// strobes; only bus_stall is combinational.
module sram_bus_responder #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_bus_responder_if.slave bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_data_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                data_oe_q, data_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [3:0]          be_n_q, be_n_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                req;

    // Byte-offset and upper address bits have no meaning for a word SRAM.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{bus.bus_address[31:ADDR_W+2], bus.bus_address[1:0]};

    assign req            = bus.bus_read | bus.bus_write;
    assign bus.bus_stall  = req && (state_q != DONE);
    assign bus.bus_data_o = rdata_q;

    assign sram_addr    = addr_q;
    assign sram_data_o  = wdata_q;
    assign sram_data_oe = data_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_be_n    = be_n_q;

    // Next-state and next-strobe logic; a dropped request aborts SETUP/ACCESS.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_oe_d  = data_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        be_n_d     = be_n_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d     = bus.bus_address[ADDR_W+1:2];
                    is_write_d = bus.bus_write;
                    ce_n_d     = 1'b0;
                    if (bus.bus_write) begin
                        wdata_d   = bus.bus_data_i;
                        data_oe_d = 1'b1;
                        oe_n_d    = 1'b1;
                        be_n_d    = ~bus.bus_byte_enable;
                    end else begin
                        data_oe_d = 1'b0;
                        oe_n_d    = 1'b0;
                        be_n_d    = 4'h0;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!req) begin
                    data_oe_d = 1'b0;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    we_n_d    = 1'b1;
                    be_n_d    = 4'hF;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    we_n_d  = ~is_write_q;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!req) begin
                    data_oe_d = 1'b0;
                    ce_n_d    = 1'b1;
                    oe_n_d    = 1'b1;
                    we_n_d    = 1'b1;
                    be_n_d    = 4'hF;
                    state_d   = IDLE;
                end else if (cnt_q == 4'd0) begin
                    if (!is_write_q) begin
                        rdata_d = sram_data_i;
                    end
                    we_n_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                data_oe_d = 1'b0;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                be_n_d    = 4'hF;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered SRAM strobes; reset forces strobes inactive at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            data_oe_q  <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_oe_q  <= data_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
- Bus slave that answers the CPU memory-stage/MMU data bus requests (read/write with byte enables) and converts them into timed cycles on an external asynchronous 32-bit SRAM.
- Stalls the pipeline through `bus_stall` until each access completes.
- Sits between `mmu_top`'s physical bus port and the board SRAM.
- Wait states are parameterised.

Parameters:
- ADDR_W, 20, SRAM word-address width. Bus byte address bits [ADDR_W+1:2] are used; all other bits are ignored.
- WAIT_CYCLES, 2, number of ACCESS-state cycles per transfer. Legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- bus_address  input  32  physical byte address; held stable by the initiator while `bus_stall`=1.
- bus_read  input  1  read request, level-held.
- bus_write  input  1  write request, level-held.
- bus_byte_enable  input  4  byte lanes for a write. Reads always return all 4 lanes.
- bus_data_i  input  32  write data.
- bus_data_o  output  32  read data. Valid in the cycle `bus_stall` drops for a read; held until the next read completes.
- bus_stall  output  1  1 = request accepted but not finished.
- sram_addr  output  ADDR_W  SRAM word address.
- sram_data_o  output  32  data driven to SRAM.
- sram_data_oe  output  1  1 = top level enables the SRAM data tristate.
- sram_data_i  input  32  data returned from SRAM.
- sram_ce_n  output  1  chip enable, active-low.
- sram_oe_n  output  1  output enable, active-low.
- sram_we_n  output  1  write enable, active-low.
- sram_be_n  output  4  byte enables, active-low.

Behaviour:
- Reset values:
  - `bus_data_o`=0, `sram_addr`=0, `sram_data_o`=0, `sram_data_oe`=0.
  - `sram_ce_n`=1, `sram_oe_n`=1, `sram_we_n`=1, `sram_be_n`=4'hF.
  - State = IDLE, wait counter = 0.
  - Reset is asynchronous: asserting `rst_n` mid-transfer forces all strobes inactive immediately.
- `bus_stall` is combinational: `(bus_read|bus_write) && state!=DONE`.
- All SRAM-side outputs are registered.
- If `bus_read` and `bus_write` are both 1, the write wins.
- State machine:
  - IDLE:
    - Request seen → latch address, direction, byte enables and write data.
    - Drive `sram_addr`, `sram_ce_n`=0.
    - Read: `sram_oe_n`=0, `sram_be_n`=0.
    - Write: `sram_data_oe`=1, `sram_be_n`=~`bus_byte_enable`.
    - Go to SETUP.
  - SETUP (1 cycle):
    - Address and data stable.
    - Load wait counter with WAIT_CYCLES-1.
    - Write: `sram_we_n`=0.
    - Go to ACCESS.
  - ACCESS (WAIT_CYCLES cycles):
    - Counter decrements each cycle.
    - On the last cycle (counter==0):
      - Read: capture `sram_data_i` into `bus_data_o`.
      - Write: deassert `sram_we_n`. Address, data and `sram_be_n` stay valid one more cycle (hold).
      - Go to DONE.
  - DONE (1 cycle):
    - `bus_stall`=0; the initiator advances.
    - Deassert `ce_n`, `oe_n`, `data_oe`, `be_n`.
    - Go to IDLE unconditionally. This gives one turnaround cycle between back-to-back accesses.
- Latency from the first request cycle to the `bus_stall`=0 cycle is 2+WAIT_CYCLES cycles. Back-to-back throughput is one transfer per 3+WAIT_CYCLES cycles.
- Write with `bus_byte_enable`=0:
  - Full cycle is still executed with `sram_be_n`=F.
  - `we_n` still pulses, with no data effect.
- Request withdrawn mid-transfer (both request lines low while in SETUP/ACCESS):
  - Abort: all strobes inactive next cycle, return to IDLE.
  - `bus_data_o` is unchanged.
- Request inputs changing while stalled: latched values are used; changes are ignored until IDLE.
- `bus_data_o` is never altered by writes.

Test Plan:
- Reset then idle:
  - All outputs at reset values.
  - `bus_read`=1 at `bus_address`=0x0000_0010 → `bus_stall`=1 for 4 cycles.
  - `sram_addr`=0x00004 and `sram_oe_n`=0 from the SETUP cycle on.
  - `bus_data_o`=model word (0xDEADBEEF) in the cycle `bus_stall` drops.
- Write with byte enables:
  - `bus_address`=0x24, `bus_data_i`=0x11223344, `bus_byte_enable`=4'b0101 → `sram_be_n`=4'b1010.
  - `sram_we_n` low for exactly 2 cycles with the address stable 1 cycle before and after.
  - Read back 0x24 → bytes 0 and 2 updated, bytes 1 and 3 unchanged.
- Back-to-back: write 0x100 then read 0x100 held consecutively → exactly 1 IDLE cycle between the two DONE cycles, and the read returns the written value.
- WAIT_CYCLES=1 build: read completes with `bus_stall` high for 3 cycles. WAIT_CYCLES=15 build: 17 cycles.
- Simultaneous `bus_read`=`bus_write`=1 → write cycle is performed and `bus_data_o` is unchanged.
- Abort and async reset:
  - Drop `bus_read` during ACCESS → strobes inactive next cycle, FSM in IDLE.
  - Pulse `rst_n` low mid-write for 0.3 cycle → `sram_we_n`=1 and `sram_ce_n`=1 before the next clock edge.
